ps2_direction_queue: RTL and testbench

PS2_DIRECTION_QUEUE -- requirements
Module: ps2_direction_queue

---
 rtl/ps2_dir_pkg.sv | 26 ++
 rtl/ps2_rx_frame.sv | 103 ++++++++++
 rtl/ps2_direction_queue.sv | 78 +++++++
 tb/tb_ps2_direction_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_dir_pkg.sv
// ps2_dir_pkg: shared direction codes, scan codes, prefix bytes and frame states.
package ps2_dir_pkg;
  typedef enum logic [2:0] {
    DIR_RIGHT   = 3'b000,
    DIR_DOWN    = 3'b001,
    DIR_LEFT    = 3'b010,
    DIR_UP      = 3'b011,
    DIR_RESTART = 3'b100
  } dir_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_st_e;
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] SC_UP      = 8'h1D;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_RESTART = 8'h29;
  localparam logic [7:0] SCX_UP     = 8'h75;
  localparam logic [7:0] SCX_LEFT   = 8'h6B;
  localparam logic [7:0] SCX_DOWN   = 8'h72;
  localparam logic [7:0] SCX_RIGHT  = 8'h74;
  // Opposite directions differ only in bit 1 (up/down, left/right).
  function automatic logic rejects(input logic [2:0] cmd, input logic [2:0] last);
    return (cmd != DIR_RESTART) && ((cmd == last) || (cmd == (last ^ 3'b010)));
  endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes and filters the PS/2 lines and assembles 11-bit frames.
module ps2_rx_frame
  import ps2_dir_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_strobe,
  output logic       o_frame_err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic          w_clk_s, w_dat_s, w_fall;
  frame_st_e     r_st, w_st_nx;
  logic [2:0]    r_bits, w_bits_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_par, w_par_nx;
  logic [TW-1:0] r_tcnt, w_tcnt_nx;
  logic          w_ok, w_err;
  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];
  // The falling edge is flagged in the same cycle the filter decides to flip.
  assign w_fall  = r_filt & ~w_clk_s & (r_fcnt == FW'(FILTER_LEN - 1));
  assign o_byte  = r_shift;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_fcnt     <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      if (w_clk_s == r_filt) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= w_clk_s;
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + FW'(1);
    end
  end
  always_comb begin
    w_st_nx    = r_st;
    w_bits_nx  = r_bits;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_ok       = 1'b0;
    w_err      = 1'b0;
    w_tcnt_nx  = (w_fall || r_st == ST_IDLE) ? '0 : r_tcnt + TW'(1);
    if (w_fall) begin
      case (r_st)
        ST_IDLE: begin
          w_err     = w_dat_s;
          w_st_nx   = w_dat_s ? ST_IDLE : ST_DATA;
          w_bits_nx = '0;
        end
        ST_DATA: begin
          w_shift_nx = {w_dat_s, r_shift[7:1]};
          w_bits_nx  = r_bits + 3'd1;
          w_st_nx    = (r_bits == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          w_par_nx = w_dat_s;
          w_st_nx  = ST_STOP;
        end
        default: begin
          w_ok    = w_dat_s & (^{r_shift, r_par});
          w_err   = ~w_ok;
          w_st_nx = ST_IDLE;
        end
      endcase
    end else if (r_st != ST_IDLE && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
      w_err   = 1'b1;
      w_st_nx = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st          <= ST_IDLE;
      r_bits        <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_tcnt        <= '0;
      o_byte_strobe <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      r_st          <= w_st_nx;
      r_bits        <= w_bits_nx;
      r_shift       <= w_shift_nx;
      r_par         <= w_par_nx;
      r_tcnt        <= w_tcnt_nx;
      o_byte_strobe <= w_ok;
      o_frame_err   <= w_err;
    end
  end
endmodule

// File: rtl/ps2_direction_queue.sv
// ps2_direction_queue: decodes PS/2 arrow/restart keys into a filtered direction-command FIFO.
module ps2_direction_queue
  import ps2_dir_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [2:0] dir_code,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] w_byte;
  logic       w_strobe;
  logic       r_ext, r_brk;
  dir_e       r_last, w_code;
  logic       w_hit, w_is_pfx, w_cmd;
  dir_e       r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic       w_empty, w_full, w_pop, w_push, w_drop;
  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_byte(w_byte), .o_byte_strobe(w_strobe), .o_frame_err(frame_err)
  );
  // The extended flag selects a disjoint code table, so plain and E0 codes never alias.
  always_comb begin
    w_hit  = 1'b1;
    w_code = DIR_RESTART;
    case ({r_ext, w_byte})
      {1'b0, SC_UP},    {1'b1, SCX_UP}:    w_code = DIR_UP;
      {1'b0, SC_LEFT},  {1'b1, SCX_LEFT}:  w_code = DIR_LEFT;
      {1'b0, SC_DOWN},  {1'b1, SCX_DOWN}:  w_code = DIR_DOWN;
      {1'b0, SC_RIGHT}, {1'b1, SCX_RIGHT}: w_code = DIR_RIGHT;
      {1'b0, SC_RESTART}:                  w_code = DIR_RESTART;
      default:                             w_hit  = 1'b0;
    endcase
  end
  assign w_is_pfx  = (w_byte == PFX_EXT) || (w_byte == PFX_BRK);
  assign w_cmd     = w_strobe & ~w_is_pfx & ~r_brk & w_hit & ~rejects(w_code, r_last);
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = ((r_wp ^ r_rp) == {1'b1, {AW{1'b0}}});
  assign w_pop     = dir_ready & ~w_empty;
  assign w_push    = w_cmd & (~w_full | w_pop);
  assign w_drop    = w_cmd & w_full & ~w_pop;
  assign dir_valid = ~w_empty;
  assign dir_code  = w_empty ? DIR_RESTART : r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_code;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_last   <= DIR_RESTART;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp   <= r_wp + (AW + 1)'(1);
        r_last <= w_code;
      end
      if (w_pop) r_rp <= r_rp + (AW + 1)'(1);
      if (w_drop) overflow <= 1'b1;
      if (w_strobe) begin
        r_ext <= (w_byte == PFX_EXT) ? 1'b1 : (w_byte == PFX_BRK) ? r_ext : 1'b0;
        r_brk <= (w_byte == PFX_BRK) ? 1'b1 : (w_byte == PFX_EXT) ? r_brk : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_direction_queue.sv
// tb_ps2_direction_queue: directed and random PS/2 frames checked against a queue-based key model.
module tb_ps2_direction_queue;
  localparam int FL = 4, FD = 4, TO = 5000, HALF = 10;
  localparam logic [2:0] UP = 3'b011, LEFT = 3'b010, DOWN = 3'b001, RIGHT = 3'b000, RESTART = 3'b100;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, dir_ready = 1'b0;
  logic dir_valid, frame_err, overflow;
  logic [2:0] dir_code;
  int n_checks = 0, n_fail = 0;
  int err_pulses = 0, err_run = 0, err_maxw = 0;
  logic [2:0] mq[$];
  logic [2:0] m_last = RESTART;
  bit m_ext = 0, m_brk = 0, m_ovf = 0;
  int m_err = 0;
  logic [7:0] plain_keys[5] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};
  logic [2:0] plain_dirs[5] = '{UP, LEFT, DOWN, RIGHT, RESTART};
  logic [7:0] ext_keys[4]   = '{8'h75, 8'h6B, 8'h72, 8'h74};
  logic [2:0] ext_dirs[4]   = '{UP, LEFT, DOWN, RIGHT};
  logic [7:0] pool[11]      = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74};

  ps2_direction_queue #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .dir_ready(dir_ready),
    .dir_valid(dir_valid), .dir_code(dir_code), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) begin
      if (err_run == 0) err_pulses++;
      err_run++;
      if (err_run > err_maxw) err_maxw = err_run;
    end else err_run = 0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit opposed(input logic [2:0] a, input logic [2:0] b);
    return (a == UP && b == DOWN) || (a == DOWN && b == UP) ||
           (a == LEFT && b == RIGHT) || (a == RIGHT && b == LEFT);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = RESTART; m_ext = 0; m_brk = 0; m_ovf = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit found = 0;
    logic [2:0] c = RESTART;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext) begin
        foreach (ext_keys[i]) if (ext_keys[i] == b) begin found = 1; c = ext_dirs[i]; end
      end else begin
        foreach (plain_keys[i]) if (plain_keys[i] == b) begin found = 1; c = plain_dirs[i]; end
      end
      if (found && !m_brk && (c == RESTART || (c != m_last && !opposed(c, m_last)))) begin
        if (mq.size() < FD) begin mq.push_back(c); m_last = c; end
        else m_ovf = 1;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic clock_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic par;
    par = ~(^b) ^ bad_par;
    clock_bit(1'b0);
    for (int i = 0; i < 8; i++) clock_bit(b[i]);
    clock_bit(par);
    clock_bit(~bad_stop);
    ps2_data = 1'b1;
    cyc(HALF);
    if (bad_par || bad_stop) m_err++;
    else model_byte(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, dir_valid, mq.size() != 0);
    check({tag, "_code"}, dir_code, mq.size() != 0 ? mq[0] : RESTART);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_errcnt"}, err_pulses, m_err);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_valid"}, dir_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check({tag, "_head"}, dir_code, mq[0]);
      dir_ready = 1'b1;
      cyc(1);
      dir_ready = 1'b0;
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    model_reset();
    cyc(2);
  endtask

  initial begin
    cyc(1);
    do_reset();
    check("rst_valid", dir_valid, 1'b0);
    check("rst_code", dir_code, RESTART);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    send_frame(8'h1D); send_frame(8'hF0); send_frame(8'h1D); send_frame(8'h1C);
    check_state("hold_two");
    cyc(30);
    check("hold_code", dir_code, UP);
    pop_check("two_a"); pop_check("two_b"); pop_check("two_empty");

    send_frame(8'h1D);
    pop_check("set_up");
    send_frame(8'h1B); send_frame(8'hE0); send_frame(8'h75);
    check_state("reject_rev_rep");

    send_frame(8'h23, 1);
    check_state("bad_parity");
    check("err_width", err_maxw, 1);
    send_frame(8'h23, 0, 1);
    check_state("bad_stop");

    clock_bit(1'b1);
    ps2_data = 1'b1;
    cyc(HALF);
    m_err++;
    check_state("start_err");

    ps2_clk = 1'b0;
    cyc(FL - 1);
    ps2_clk = 1'b1;
    cyc(20);
    check_state("glitch");
    send_frame(8'h1C);
    pop_check("after_glitch");

    send_frame(8'h29); send_frame(8'h1D); send_frame(8'h1C); send_frame(8'h1B); send_frame(8'h23);
    check_state("full_drop");
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("drain_full");
    check("ovf_sticky", overflow, 1'b1);

    do_reset();
    check("ovf_cleared", overflow, 1'b0);
    clock_bit(1'b0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1);
    cyc(TO + 30);
    m_err++;
    check_state("timeout");
    send_frame(8'h1D);
    check_state("after_timeout");
    pop_check("after_timeout_pop");

    clock_bit(1'b0);
    clock_bit(1'b1);
    ps2_data = 1'b1;
    do_reset();
    check_state("mid_reset");
    send_frame(8'h1C);
    check_state("after_mid_reset");

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 10)];
      send_frame(b, $urandom_range(0, 9) == 0);
      check_state("rand");
      repeat ($urandom_range(0, 2)) pop_check("rand_pop");
    end
    while (mq.size() != 0) pop_check("final_drain");
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
